// File: rtl/addsub_acc.sv
// ============================================================================
// addsub_acc : registered signed add/sub/accumulate with carry, overflow,
//              optional saturation and a saturating overflow counter. Rev 1.0
// ============================================================================
`default_nettype none

module addsub_acc #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic          carryin,
    input  logic          sat_en,
    input  logic [N-1:0]  X,
    input  logic [N-1:0]  Y,
    input  logic          clr_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  S,
    output logic          carryout,
    output logic          overflow,
    output logic [N-1:0]  acc,
    output logic [CW-1:0] ovf_count
);

    localparam logic [1:0]    OP_ADD  = 2'b00;
    localparam logic [1:0]    OP_SUB  = 2'b01;
    localparam logic [1:0]    OP_ACC  = 2'b10;
    localparam logic [1:0]    OP_CLR  = 2'b11;
    localparam logic [N-1:0]  MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          accept;
    logic [N-1:0]  opa;
    logic [N-1:0]  opb;
    logic          cin;
    logic [N:0]    sum;
    logic [N-1:0]  raw;
    logic          ovf_raw;
    logic [N-1:0]  res;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // CLR feeds zeros with no carry, so the raw sum and flags come out 0.
    always_comb begin
        opa = '0;
        opb = '0;
        cin = 1'b0;
        unique case (op)
            OP_ADD: begin
                opa = X;
                opb = Y;
                cin = carryin;
            end
            OP_SUB: begin
                opa = X;
                opb = ~Y;
                cin = carryin;
            end
            OP_ACC: begin
                opa = acc;
                opb = X;
                cin = carryin;
            end
            OP_CLR: begin
                opa = '0;
                opb = '0;
                cin = 1'b0;
            end
            default: begin
                opa = '0;
                opb = '0;
                cin = 1'b0;
            end
        endcase
    end

    always_comb begin
        sum     = {1'b0, opa} + {1'b0, opb} + {{N{1'b0}}, cin};
        raw     = sum[N-1:0];
        ovf_raw = (opa[N-1] == opb[N-1]) && (raw[N-1] != opa[N-1]);
        res     = raw;
        if (sat_en && ovf_raw) begin
            res = opa[N-1] ? MIN_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            S         <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            S         <= res;
            carryout  <= sum[N];
            overflow  <= ovf_raw;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (accept) begin
            if (op == OP_ACC) begin
                acc <= res;
            end else if (op == OP_CLR) begin
                acc <= '0;
            end
        end
    end

    // Clear wins over a same-cycle increment and ignores the handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= '0;
        end else if (accept && ovf_raw && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/addsub_acc.md
# addsub_acc

Parametrised, registered signed add/subtract/accumulate unit with carry, two's-complement overflow detection, optional saturation and a saturating overflow event counter. It is the clocked successor to the team's combinational N-bit adder-with-overflow. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. Results appear one cycle after acceptance and stall under backpressure without losing data.

## Interface
- N, 8, operand/result width in bits (N >= 2)
- CW, 4, width of overflow event counter

- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- carryin  in  1  carry/borrow-in (SUB: 1 gives X-Y)
- sat_en  in  1  saturate result on overflow (sampled with beat)
- X, Y  in  N  signed operands
- clr_count  in  1  synchronous clear of ovf_count
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- S  out  N  result (registered)
- carryout  out  1  raw carry-out of N-bit sum
- overflow  out  1  raw signed overflow of this beat
- acc  out  N  accumulator register
- ovf_count  out  CW  overflow events, saturating

## Operation
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready.
- Operands per op, with sum = A + B + carryin computed at N+1 bits:
  - ADD: A=X, B=Y.
  - SUB: A=X, B=~Y.
  - ACC: A=acc, B=X; Y is ignored.
- Raw results:
  - R = sum[N-1:0]; carryout = sum[N].
  - overflow = (A[N-1]==B[N-1]) && (R[N-1]!=A[N-1]).
  - For SUB this equals X/Y signs differing with the result sign differing from X.
- Saturation: if sat_en && overflow, S = A[N-1] ? 100..0 : 011..1; otherwise S = R. carryout and overflow always report the raw values.
- ACC: acc <= S (the saturated value when saturating) on accept.
- CLR: acc <= 0; the beat still produces output S=0, carryout=0, overflow=0.
- ADD/SUB leave acc unchanged.
- ovf_count:
  - Increments on each accepted beat with overflow=1, holding at 2^CW-1.
  - clr_count sets it to 0 and has priority over a same-cycle increment.

## Timing
- Reset (async assert, sync-safe release) sets S, carryout, overflow, acc, ovf_count and out_valid to 0, which makes in_ready=1.
- Latency: a beat accepted at edge k is presented at S/flags with out_valid=1 from after edge k until the cycle it is consumed.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, the output registers, acc and ovf_count hold and in_ready=0.
- Simultaneous consume and accept in one cycle: the output is replaced by the new beat and out_valid stays 1.
- Consume with no accept: out_valid <= 0 at the next edge.
- Back-to-back ACC beats chain through the updated acc with no bubble.
- Reset mid-stream discards the in-flight result; no output beat is produced.
- clr_count acts regardless of the handshake state.

## Test plan
- ADD, N=8, sat_en=0, carryin=0:
  - 64+64 -> S=0x80, carryout=0, overflow=1, ovf_count=1.
  - 127+(-1) -> S=0x7E, carryout=1, overflow=0.
  - -63+(-65) -> S=0x80, carryout=1, overflow=0.
- Saturation:
  - ADD 64+64 with sat_en=1 -> S=0x7F, overflow=1.
  - SUB -128-2 (carryin=1) with sat_en=0 -> S=0x7E, carryout=1, overflow=1.
  - SUB -128-2 with sat_en=1 -> S=0x80.
- Accumulate: CLR, then ACC X=100 twice with sat_en=1:
  - Results 0, 100, 127; acc=127 at the end.
  - Last beat has overflow=1; ovf_count increments by 1.
- Backpressure:
  - Stream 4 ADD beats with out_ready low for 3 cycles mid-stream.
  - No beat is lost or duplicated; S is stable while stalled; in_ready=0 during the stall.
- Counter:
  - With CW=2, 5 overflowing beats -> ovf_count=3.
  - clr_count asserted in the same cycle as an overflowing accept -> ovf_count=0.
- Reset:
  - Assert resetn=0 while out_valid=1 and acc nonzero.
  - All outputs read 0 immediately (asynchronous); in_ready=1 after release.
